// File: rtl/bt656_pkg.sv
// Shared BT.656 word constants and helpers, used by this encoder and by the sync parser.
package bt656_pkg;

  localparam logic [9:0] PREAMBLE_1 = 10'h3FF;
  localparam logic [9:0] PREAMBLE_0 = 10'h000;
  localparam logic [9:0] BLANK_EVEN = 10'h200;
  localparam logic [9:0] BLANK_ODD  = 10'h040;
  localparam logic [9:0] CLIP_LO    = 10'h004;
  localparam logic [9:0] CLIP_HI    = 10'h3FB;

  typedef enum logic [1:0] {
    SEG_EAV,
    SEG_HBLANK,
    SEG_SAV,
    SEG_ACTIVE
  } segment_t;

  // Fourth word of an EAV/SAV: flags plus Hamming-style protection bits.
  function automatic logic [9:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

  function automatic logic [9:0] clip_word(input logic [9:0] w);
    if (w < CLIP_LO) return CLIP_LO;
    if (w > CLIP_HI) return CLIP_HI;
    return w;
  endfunction

endpackage

// File: rtl/bt656_raster_counter.sv
// Raster timing for the BT.656 encoder: word/line counters, segment FSM and
// per-line F/V flags. h_cnt names the word that the encoder emits next cycle.
module bt656_raster_counter
  import bt656_pkg::*;
#(
  parameter int H_ACTIVE    = 1440,
  parameter int H_BLANK     = 276,
  parameter int LINES       = 525,
  parameter int F_FALL_LINE = 4,
  parameter int F_RISE_LINE = 266,
  parameter int ACT1_FIRST  = 20,
  parameter int ACT1_LAST   = 263,
  parameter int ACT2_FIRST  = 283,
  parameter int ACT2_LAST   = 525
) (
  input  logic       clk,
  input  logic       reset,
  output segment_t   seg,
  output logic [1:0] ref_idx,
  output logic       blank_odd,
  output logic [9:0] line,
  output logic       f_flag,
  output logic       v_flag
);

  localparam int LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);

  localparam logic [HW-1:0] LAST_WORD   = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] EAV_LAST    = HW'(3);
  localparam logic [HW-1:0] HBLANK_LAST = HW'(H_BLANK - 5);
  localparam logic [HW-1:0] SAV_LAST    = HW'(H_BLANK - 1);
  localparam logic [1:0]    SAV_PHASE   = 2'(H_BLANK - 4);

  localparam logic [9:0] LAST_LINE = 10'(LINES);
  localparam logic [9:0] F_FALL    = 10'(F_FALL_LINE);
  localparam logic [9:0] F_RISE    = 10'(F_RISE_LINE);
  localparam logic [9:0] A1_FIRST  = 10'(ACT1_FIRST);
  localparam logic [9:0] A1_LAST   = 10'(ACT1_LAST);
  localparam logic [9:0] A2_FIRST  = 10'(ACT2_FIRST);
  localparam logic [9:0] A2_LAST   = 10'(ACT2_LAST);

  logic [HW-1:0] h_cnt, h_cnt_next;
  logic [9:0]    line_next;
  segment_t      seg_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      line  <= 10'd1;
      seg   <= SEG_EAV;
    end else begin
      h_cnt <= h_cnt_next;
      line  <= line_next;
      seg   <= seg_next;
    end
  end

  // With the minimum 8-word blanking there is no HBLANK segment at all.
  always_comb begin
    h_cnt_next = h_cnt + HW'(1);
    line_next  = line;
    seg_next   = seg;
    if (h_cnt == LAST_WORD) begin
      h_cnt_next = '0;
      line_next  = (line == LAST_LINE) ? 10'd1 : line + 10'd1;
    end
    unique case (seg)
      SEG_EAV:    if (h_cnt == EAV_LAST)    seg_next = (H_BLANK == 8) ? SEG_SAV : SEG_HBLANK;
      SEG_HBLANK: if (h_cnt == HBLANK_LAST) seg_next = SEG_SAV;
      SEG_SAV:    if (h_cnt == SAV_LAST)    seg_next = SEG_ACTIVE;
      SEG_ACTIVE: if (h_cnt == LAST_WORD)   seg_next = SEG_EAV;
    endcase
  end

  assign ref_idx   = (seg == SEG_SAV) ? h_cnt[1:0] - SAV_PHASE : h_cnt[1:0];
  assign blank_odd = h_cnt[0];

  assign f_flag = (line < F_FALL) || (line >= F_RISE);
  assign v_flag = !(((line >= A1_FIRST) && (line <= A1_LAST)) ||
                    ((line >= A2_FIRST) && (line <= A2_LAST)));

endmodule

// File: rtl/bt656_encoder.sv
// BT.656 10-bit 4:2:2 transmitter: muxes timing references, blanking and
// clipped active video into a registered word stream with aligned H/V/F/line.
module bt656_encoder
  import bt656_pkg::*;
#(
  parameter int H_ACTIVE    = 1440,
  parameter int H_BLANK     = 276,
  parameter int LINES       = 525,
  parameter int F_FALL_LINE = 4,
  parameter int F_RISE_LINE = 266,
  parameter int ACT1_FIRST  = 20,
  parameter int ACT1_LAST   = 263,
  parameter int ACT2_FIRST  = 283,
  parameter int ACT2_LAST   = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_data,
  output logic       pix_ready,
  output logic [9:0] bt_656,
  output logic       H,
  output logic       V,
  output logic       F,
  output logic [9:0] line
);

  segment_t   seg;
  logic [1:0] ref_idx;
  logic       blank_odd;
  logic [9:0] raster_line;
  logic       f_flag;
  logic       v_flag;
  logic [9:0] word_next;
  logic       h_flag;

  bt656_raster_counter #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .LINES       (LINES),
    .F_FALL_LINE (F_FALL_LINE),
    .F_RISE_LINE (F_RISE_LINE),
    .ACT1_FIRST  (ACT1_FIRST),
    .ACT1_LAST   (ACT1_LAST),
    .ACT2_FIRST  (ACT2_FIRST),
    .ACT2_LAST   (ACT2_LAST)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .ref_idx   (ref_idx),
    .blank_odd (blank_odd),
    .line      (raster_line),
    .f_flag    (f_flag),
    .v_flag    (v_flag)
  );

  // Active words are clipped so video can never mimic a 3FF/000 preamble.
  always_comb begin
    word_next = BLANK_ODD;
    unique case (seg)
      SEG_EAV, SEG_SAV: begin
        case (ref_idx)
          2'd0:    word_next = PREAMBLE_1;
          2'd3:    word_next = xy_code(f_flag, v_flag, seg == SEG_EAV);
          default: word_next = PREAMBLE_0;
        endcase
      end
      SEG_HBLANK: word_next = blank_odd ? BLANK_ODD : BLANK_EVEN;
      SEG_ACTIVE: word_next = clip_word(pix_data);
    endcase
  end

  assign h_flag    = (seg == SEG_EAV) || (seg == SEG_HBLANK);
  assign pix_ready = (seg == SEG_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      bt_656 <= BLANK_ODD;
      H      <= 1'b1;
      V      <= 1'b1;
      F      <= 1'b1;
      line   <= 10'd1;
    end else begin
      bt_656 <= word_next;
      H      <= h_flag;
      V      <= v_flag;
      F      <= f_flag;
      line   <= raster_line;
    end
  end

endmodule
